// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_e;

   localparam int         BCD_DIGIT_WIDTH      = 4;
   localparam logic [3:0] BCD_ADJUST           = 4'd3;
   localparam logic [3:0] BCD_ADJUST_THRESHOLD = 4'd5;

endpackage

// File: rtl/binary_to_bcd_seq_if.sv
// Request/result bundle between the counter side and the display driver.
interface binary_to_bcd_seq_if #(
   parameter int INPUT_WIDTH = 32,
   parameter int DIGIT_COUNT = 8
);

   logic                       start;
   logic [INPUT_WIDTH-1:0]     value;
   logic [4*DIGIT_COUNT-1:0]   bcd;
   logic [DIGIT_COUNT-1:0]     digit_enable;
   logic                       valid;
   logic                       busy;
   logic                       overflow;

   modport master (
      output start, value,
      input  bcd, digit_enable, valid, busy, overflow
   );

   modport slave (
      input  start, value,
      output bcd, digit_enable, valid, busy, overflow
   );

endinterface

// File: rtl/binary_to_bcd_seq_digit_adjust.sv
// One BCD digit of the add-3 correction; no carry leaves the digit.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_WIDTH-1:0] digit_i,
   output logic [BCD_DIGIT_WIDTH-1:0] digit_o
);

   always_comb begin
      digit_o = digit_i;
      if (digit_i >= BCD_ADJUST_THRESHOLD) begin
         digit_o = digit_i + BCD_ADJUST;
      end
   end

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Double-dabble converter, one input bit per clock, with blanking mask.
module binary_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int INPUT_WIDTH = 32,
   parameter int DIGIT_COUNT = 8
) (
   input logic                clk,
   input logic                reset,
   binary_to_bcd_seq_if.slave bus
);

   localparam int AW = BCD_DIGIT_WIDTH * DIGIT_COUNT;
   localparam int CW = $clog2(INPUT_WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(INPUT_WIDTH - 1);
   localparam logic [AW-1:0] ALL_NINES = {DIGIT_COUNT{4'h9}};

   state_e                 state_q, state_d;
   logic [INPUT_WIDTH-1:0] sr_q, sr_d;
   logic [AW-1:0]          acc_q, acc_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   sticky_q, sticky_d;
   logic [AW-1:0]          bcd_q, bcd_d;
   logic [DIGIT_COUNT-1:0] den_q, den_d;
   logic                   ovf_q, ovf_d;
   logic                   valid_q, valid_d;
   logic                   busy_q, busy_d;

   logic [AW-1:0]          adj;
   logic                   shout;
   logic [AW-1:0]          bcd_new;
   logic [DIGIT_COUNT-1:0] den_new;
   logic                   seen;
   logic                   load;

   for (genvar g = 0; g < DIGIT_COUNT; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .digit_i (acc_q[g*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH]),
         .digit_o (adj[g*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH])
      );
   end

   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      valid_d  = 1'b0;
      load     = 1'b0;
      shout    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               sr_d     = bus.value;
               acc_d    = '0;
               cnt_d    = '0;
               sticky_d = 1'b0;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            {shout, acc_d, sr_d} = {adj, sr_q, 1'b0};
            sticky_d = sticky_q | shout;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               load    = 1'b1;
               valid_d = 1'b1;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // A digit is lit when it or any more significant digit is nonzero.
   always_comb begin
      bcd_new = sticky_d ? ALL_NINES : acc_d;
      den_new = '0;
      seen    = 1'b0;
      for (int i = DIGIT_COUNT - 1; i >= 0; i--) begin
         seen       = seen | (bcd_new[i*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH] != '0);
         den_new[i] = seen;
      end
      den_new[0] = 1'b1;
      bcd_d = load ? bcd_new  : bcd_q;
      den_d = load ? den_new  : den_q;
      ovf_d = load ? sticky_d : ovf_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         sr_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
         bcd_q    <= '0;
         den_q    <= DIGIT_COUNT'(1);
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
         bcd_q    <= bcd_d;
         den_q    <= den_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.bcd          = bcd_q;
   assign bus.digit_enable = den_q;
   assign bus.overflow     = ovf_q;
   assign bus.valid        = valid_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed checks of binary_to_bcd_seq: conversions, overflow, start and reset.
module tb_binary_to_bcd_seq;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   int   n_pulse;
   int   v_cyc;
   int   v_cyc2;
   logic [31:0] r_bcd;
   logic [31:0] r_bcd2;
   logic [7:0]  r_den;
   logic        r_ovf;

   binary_to_bcd_seq_if #(.INPUT_WIDTH(32), .DIGIT_COUNT(8)) bus ();

   binary_to_bcd_seq #(.INPUT_WIDTH(32), .DIGIT_COUNT(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Start in cycle 0, watch cycles 1..40 for the result pulse.
   task automatic conv(input logic [31:0] v);
      n_pulse = 0;
      v_cyc   = -1;
      bus.start = 1'b1;
      bus.value = v;
      for (int c = 1; c <= 40; c++) begin
         step();
         bus.start = 1'b0;
         if (bus.valid === 1'b1) begin
            n_pulse++;
            v_cyc = c;
            r_bcd = bus.bcd;
            r_den = bus.digit_enable;
            r_ovf = bus.overflow;
         end
      end
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      bus.start = 1'b0;
      bus.value = '0;
      reset     = 1'b1;
      repeat (3) step();
      chk("rst_bcd", bus.bcd, 32'h0);
      chk("rst_den", {24'h0, bus.digit_enable}, 32'h01);
      chk("rst_valid", {31'h0, bus.valid}, 32'h0);
      chk("rst_busy", {31'h0, bus.busy}, 32'h0);
      chk("rst_ovf", {31'h0, bus.overflow}, 32'h0);
      reset = 1'b0;
      step();

      conv(32'd0);
      chk("z_cycle", v_cyc, 33);
      chk("z_pulses", n_pulse, 1);
      chk("z_bcd", r_bcd, 32'h0);
      chk("z_den", {24'h0, r_den}, 32'h01);
      chk("z_ovf", {31'h0, r_ovf}, 32'h0);

      conv(32'h00BC614E);
      chk("m_bcd", r_bcd, 32'h12345678);
      chk("m_den", {24'h0, r_den}, 32'hFF);
      chk("m_ovf", {31'h0, r_ovf}, 32'h0);
      chk("m_hold", bus.bcd, 32'h12345678);

      conv(32'd1000);
      chk("k_bcd", r_bcd, 32'h00001000);
      chk("k_den", {24'h0, r_den}, 32'h0F);

      conv(32'h05F5E0FF);
      chk("max_bcd", r_bcd, 32'h99999999);
      chk("max_ovf", {31'h0, r_ovf}, 32'h0);

      conv(32'h05F5E100);
      chk("ov_bcd", r_bcd, 32'h99999999);
      chk("ov_ovf", {31'h0, r_ovf}, 32'h1);
      chk("ov_den", {24'h0, r_den}, 32'hFF);

      conv(32'hFFFFFFFF);
      chk("ff_ovf", {31'h0, r_ovf}, 32'h1);
      chk("ff_bcd", r_bcd, 32'h99999999);

      // Start handling: retriggers in 5 and 33 ignored, 34 accepted.
      n_pulse   = 0;
      v_cyc     = -1;
      v_cyc2    = -1;
      bus.start = 1'b1;
      bus.value = 32'd5;
      for (int c = 1; c <= 70; c++) begin
         step();
         if (bus.valid === 1'b1) begin
            n_pulse++;
            if (n_pulse == 1) begin
               v_cyc = c;
               r_bcd = bus.bcd;
            end else begin
               v_cyc2 = c;
               r_bcd2 = bus.bcd;
            end
         end
         if (c == 1)  chk("s_busy1", {31'h0, bus.busy}, 32'h1);
         if (c == 33) chk("s_busy33", {31'h0, bus.busy}, 32'h1);
         if (c == 34) chk("s_busy34", {31'h0, bus.busy}, 32'h0);
         bus.start = (c == 5 || c == 33 || c == 34);
         if (c == 5)  bus.value = 32'd7;
         if (c == 34) bus.value = 32'd42;
      end
      bus.start = 1'b0;
      chk("s_pulses", n_pulse, 2);
      chk("s_cyc1", v_cyc, 33);
      chk("s_bcd1", r_bcd, 32'h5);
      chk("s_cyc2", v_cyc2, 67);
      chk("s_bcd2", r_bcd2, 32'h42);

      // Asynchronous reset in cycle 10 of a conversion.
      bus.start = 1'b1;
      bus.value = 32'h00BC614E;
      for (int c = 1; c <= 10; c++) begin
         step();
         bus.start = 1'b0;
      end
      chk("r_busy_pre", {31'h0, bus.busy}, 32'h1);
      #2;
      reset = 1'b1;
      #1;
      chk("r_busy", {31'h0, bus.busy}, 32'h0);
      chk("r_valid", {31'h0, bus.valid}, 32'h0);
      chk("r_bcd", bus.bcd, 32'h0);
      chk("r_ovf", {31'h0, bus.overflow}, 32'h0);
      chk("r_den", {24'h0, bus.digit_enable}, 32'h01);
      step();
      reset = 1'b0;
      n_pulse = 0;
      for (int c = 1; c <= 40; c++) begin
         step();
         if (bus.valid === 1'b1) n_pulse++;
      end
      chk("r_no_valid", n_pulse, 0);

      conv(32'd1000);
      chk("r_after_cyc", v_cyc, 33);
      chk("r_after_bcd", r_bcd, 32'h00001000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/binary_to_bcd_seq.md
# binary_to_bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble, one bit per clock) that sits between the free-running counter and the hex seven-segment display driver. It turns the binary count into packed BCD nibbles so the display shows decimal. It also produces a leading-zero-blanking mask that feeds the driver's per-digit display enable.

## Interface
- INPUT_WIDTH, 32, width of the binary input value
- DIGIT_COUNT, 8, number of BCD digits produced (one per display)
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a conversion of `value`; sampled only in IDLE
- value  input  INPUT_WIDTH  binary value, latched on accepted start
- bcd  output  4*DIGIT_COUNT  packed BCD result, digit 0 in bits [3:0]
- digit_enable  output  DIGIT_COUNT  leading-zero-blanking mask for the display driver
- valid  output  1  one-cycle pulse, result just updated
- busy  output  1  high while a conversion is in progress (SHIFT or DONE)
- overflow  output  1  value exceeds 10^DIGIT_COUNT−1; held with the result

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - latch `value` into the shift register
  - clear the BCD accumulator, bit counter and overflow-sticky
  - go to SHIFT
- SHIFT, each cycle:
  - every digit ≥5 gets +3
  - then shift {accumulator, shift register} left by 1
  - bit counter increments
  - any 1 shifted out of the top digit sets overflow-sticky
  - after INPUT_WIDTH shifts, go to DONE
- DONE (exactly one cycle):
  - register outputs: `bcd` = accumulator (all 9s if overflow-sticky), `overflow` = sticky, `digit_enable`
  - valid=1
  - then go to IDLE
- digit_enable[i] = 1 if any digit j ≥ i is nonzero. digit_enable[0] is always 1.
- start in SHIFT or DONE is ignored; no queueing.
- `value` changes after acceptance have no effect.
- bcd, digit_enable and overflow hold their last result until the next DONE.
- Reset values:
  - state IDLE, bcd 0
  - digit_enable = 1 (only bit 0 set)
  - valid 0, busy 0, overflow 0
- Reset mid-conversion: aborts immediately to reset values. No valid pulse for the aborted conversion.

## Timing
- Cycle numbering: start high in cycle 0 (IDLE). Cycles 1..INPUT_WIDTH are SHIFT. Cycle INPUT_WIDTH+1 is DONE.
- busy is high in cycles 1..INPUT_WIDTH+1.
- valid and the new result are visible in cycle INPUT_WIDTH+1; for default width, valid in cycle 33.
- Earliest next accepted start: cycle INPUT_WIDTH+2. Throughput is one conversion per INPUT_WIDTH+2 cycles, far faster than the 4 Hz count enable.
- All outputs are registered; no combinational input-to-output path.
- Width rules:
  - shift register is INPUT_WIDTH bits; accumulator is 4*DIGIT_COUNT bits
  - bit counter is $clog2(INPUT_WIDTH+1) bits
  - the add-3 compare is per 4-bit digit, with no carry between digits

## Structure
- Package `bcd_pkg`:
  - typedef enum for state {IDLE, SHIFT, DONE}
  - constants BCD_DIGIT_WIDTH = 4, BCD_ADJUST = 3, BCD_ADJUST_THRESHOLD = 5
- Sub-module `bcd_digit_adjust`: combinational, 4-bit in/out, adds 3 when ≥5. Instantiated DIGIT_COUNT times via generate.
- Top module holds the FSM, shift/accumulator registers, overflow-sticky, output registers and blanking logic.

## Test plan
- reset, then start with value=0 → valid exactly in cycle 33; bcd=32'h00000000, digit_enable=8'h01, overflow=0.
- value=12345678 (32'h00BC614E) → bcd=32'h12345678, digit_enable=8'hFF, overflow=0. Then value=1000 → bcd=32'h00001000, digit_enable=8'h0F.
- Overflow boundary:
  - value=99999999 (32'h05F5E0FF) → bcd=32'h99999999, overflow=0
  - value=100000000 (32'h05F5E100) → overflow=1, bcd=32'h99999999
  - value=32'hFFFFFFFF → overflow=1
- Start handling:
  - start re-asserted in cycles 5 and 33 → ignored; exactly one valid pulse
  - start in cycle 34 accepted; second valid in cycle 67
  - `value` changed during SHIFT has no effect on the result
- reset asserted in cycle 10 of a conversion → busy, valid, bcd and overflow drop to reset values asynchronously; no valid follows. A new start after reset converts correctly.
